// File: rtl/banked_mem_pkg.sv
// Shared helpers for banked_ported_memory: index widths, strobe width and bank select.
package banked_mem_pkg;

    localparam int unsigned BYTE_BITS = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_shift(input int unsigned nbanks);
        return $clog2(nbanks);
    endfunction

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    // Bank count is a power of two, so the bank is just the low address bits.
    function automatic int unsigned bank_sel(input logic [63:0] addr, input int unsigned nbanks);
        return 32'(addr & 64'(nbanks - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, pointer moves past the winner.
module rr_arbiter
    import banked_mem_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PW = idx_width(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   cand;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr_q) + off) % N;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                ptr_d       = PW'((cand + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/banked_ported_memory.sv
// Multi-bank, multi-port word memory with per-bank round-robin arbitration and 1-cycle reads.
// Define BANKED_MEM_FWD_EN for write-first same-address forwarding; default is read-first.
module banked_ported_memory
    import banked_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_SIZE        = 1024,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned NUM_READ_PORTS  = 2,
    parameter int unsigned NUM_WRITE_PORTS = 1,
    parameter              NAME            = "MEM"
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_READ_PORTS-1:0]                       rd_req_valid,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]       rd_addr,
    output logic [NUM_READ_PORTS-1:0]                       rd_req_ready,
    output logic [NUM_READ_PORTS-1:0]                       rd_resp_valid,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]       rd_resp_data,
    input  logic [NUM_WRITE_PORTS-1:0]                      wr_req_valid,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]      wr_addr,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]      wr_data,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH/8-1:0]    wr_strb,
    output logic [NUM_WRITE_PORTS-1:0]                      wr_req_ready
);

    localparam int unsigned STRB_W  = strb_width(DATA_WIDTH);
    localparam int unsigned BANK_SH = bank_shift(NUM_BANKS);
    localparam int unsigned BANK_W  = idx_width(NUM_BANKS);
    localparam int unsigned ROWS    = MEM_SIZE / NUM_BANKS;
    localparam int unsigned ROW_W   = idx_width(ROWS);

    if ($bits(NAME) % BYTE_BITS != 0) begin : g_odd_name_tag
    end

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];

    logic [NUM_READ_PORTS-1:0][BANK_W-1:0]  rd_bank;
    logic [NUM_READ_PORTS-1:0][ROW_W-1:0]   rd_row;
    logic [NUM_READ_PORTS-1:0]              rd_inr;
    logic [NUM_WRITE_PORTS-1:0][BANK_W-1:0] wr_bank;
    logic [NUM_WRITE_PORTS-1:0][ROW_W-1:0]  wr_row;
    logic [NUM_WRITE_PORTS-1:0]             wr_inr;

    logic [NUM_BANKS-1:0][NUM_READ_PORTS-1:0]  rd_bank_req, rd_bank_gnt;
    logic [NUM_BANKS-1:0][NUM_WRITE_PORTS-1:0] wr_bank_req, wr_bank_gnt;

    logic [NUM_READ_PORTS-1:0]                 rd_resp_valid_q, rd_resp_valid_d;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_resp_data_q, rd_resp_data_d;

    // Out-of-range requests still arbitrate for the bank their low bits select.
    always_comb begin
        rd_bank     = '0;
        rd_row      = '0;
        rd_inr      = '0;
        rd_bank_req = '0;
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            rd_bank[p] = BANK_W'(bank_sel(64'(rd_addr[p]), NUM_BANKS));
            rd_row[p]  = ROW_W'(rd_addr[p] >> BANK_SH);
            rd_inr[p]  = 64'(rd_addr[p]) < 64'(MEM_SIZE);
            rd_bank_req[rd_bank[p]][p] = rd_req_valid[p];
        end
        wr_bank     = '0;
        wr_row      = '0;
        wr_inr      = '0;
        wr_bank_req = '0;
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++) begin
            wr_bank[w] = BANK_W'(bank_sel(64'(wr_addr[w]), NUM_BANKS));
            wr_row[w]  = ROW_W'(wr_addr[w] >> BANK_SH);
            wr_inr[w]  = 64'(wr_addr[w]) < 64'(MEM_SIZE);
            wr_bank_req[wr_bank[w]][w] = wr_req_valid[w];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_READ_PORTS)) u_rd_arb (
            .clk    (clk),
            .rst_ni (reset_n),
            .req_i  (rd_bank_req[b]),
            .gnt_o  (rd_bank_gnt[b])
        );
        rr_arbiter #(.N(NUM_WRITE_PORTS)) u_wr_arb (
            .clk    (clk),
            .rst_ni (reset_n),
            .req_i  (wr_bank_req[b]),
            .gnt_o  (wr_bank_gnt[b])
        );
    end

    always_comb begin
        rd_req_ready = '0;
        wr_req_ready = '0;
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            rd_req_ready[p] = rd_bank_gnt[rd_bank[p]][p];
        end
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++) begin
            wr_req_ready[w] = wr_bank_gnt[wr_bank[w]][w];
        end
    end

    always_comb begin
        rd_resp_valid_d = rd_req_ready;
        rd_resp_data_d  = rd_resp_data_q;
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            if (rd_req_ready[p]) begin
                rd_resp_data_d[p] = rd_inr[p] ? mem_q[rd_bank[p]][rd_row[p]] : '0;
`ifdef BANKED_MEM_FWD_EN
                // Only one write can win a bank, so at most one port matches here.
                for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (wr_req_ready[w] && wr_inr[w] && rd_inr[p] && (wr_addr[w] == rd_addr[p])) begin
                        for (int unsigned i = 0; i < STRB_W; i++) begin
                            if (wr_strb[w][i]) begin
                                rd_resp_data_d[p][BYTE_BITS*i +: BYTE_BITS] =
                                    wr_data[w][BYTE_BITS*i +: BYTE_BITS];
                            end
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_resp_valid_q <= '0;
            rd_resp_data_q  <= '0;
        end else begin
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_resp_data_q  <= rd_resp_data_d;
        end
    end

    // Storage is deliberately outside reset.
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (wr_req_ready[w] && wr_inr[w]) begin
                for (int unsigned i = 0; i < STRB_W; i++) begin
                    if (wr_strb[w][i]) begin
                        mem_q[wr_bank[w]][wr_row[w]][BYTE_BITS*i +: BYTE_BITS] <=
                            wr_data[w][BYTE_BITS*i +: BYTE_BITS];
                    end
                end
            end
        end
    end

    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_banked_ported_memory.sv
// Self-checking bench for banked_ported_memory: directed vectors plus random traffic vs a reference model.
module tb_banked_ported_memory;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MS = 1024;
    localparam int NB = 4;
    localparam int NR = 2;
    localparam int NW = 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NR-1:0]          rd_req_valid, rd_req_ready, rd_resp_valid;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic [NR-1:0][DW-1:0]  rd_resp_data;
    logic [NW-1:0]          wr_req_valid, wr_req_ready;
    logic [NW-1:0][AW-1:0]  wr_addr;
    logic [NW-1:0][DW-1:0]  wr_data;
    logic [NW-1:0][DW/8-1:0] wr_strb;

    banked_ported_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_BANKS(NB),
        .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW), .NAME("MEM")
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_req_valid(wr_req_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_req_ready(wr_req_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [MS];
    int            rd_ptr [NB];
    int            wr_ptr [NB];
    logic [DW-1:0] last_data [NR];
    logic [NR-1:0] exp_rd_rdy;
    logic [NW-1:0] exp_wr_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            rd_ptr[b] = 0;
            wr_ptr[b] = 0;
        end
        for (int p = 0; p < NR; p++) last_data[p] = '0;
    endtask

    // Grant = first requester of the bank found scanning from the pointer.
    task automatic model_eval();
        bit done;
        int p;
        exp_rd_rdy = '0;
        exp_wr_rdy = '0;
        for (int b = 0; b < NB; b++) begin
            done = 0;
            for (int k = 0; k < NR; k++) begin
                p = (rd_ptr[b] + k) % NR;
                if (!done && rd_req_valid[p] && (int'(rd_addr[p] % NB) == b)) begin
                    exp_rd_rdy[p] = 1'b1;
                    done = 1;
                end
            end
            done = 0;
            for (int k = 0; k < NW; k++) begin
                p = (wr_ptr[b] + k) % NW;
                if (!done && wr_req_valid[p] && (int'(wr_addr[p] % NB) == b)) begin
                    exp_wr_rdy[p] = 1'b1;
                    done = 1;
                end
            end
        end
    endtask

    task automatic model_commit();
        logic [DW-1:0] d;
        for (int p = 0; p < NR; p++) begin
            if (exp_rd_rdy[p]) begin
                d = (rd_addr[p] < MS) ? ref_mem[int'(rd_addr[p])] : '0;
`ifdef BANKED_MEM_FWD_EN
                for (int w = 0; w < NW; w++)
                    if (exp_wr_rdy[w] && wr_addr[w] == rd_addr[p] && rd_addr[p] < MS)
                        for (int i = 0; i < DW/8; i++)
                            if (wr_strb[w][i]) d[8*i +: 8] = wr_data[w][8*i +: 8];
`endif
                last_data[p] = d;
                rd_ptr[int'(rd_addr[p] % NB)] = (p + 1) % NR;
            end
        end
        for (int w = 0; w < NW; w++) begin
            if (exp_wr_rdy[w]) begin
                if (wr_addr[w] < MS)
                    for (int i = 0; i < DW/8; i++)
                        if (wr_strb[w][i]) ref_mem[int'(wr_addr[w])][8*i +: 8] = wr_data[w][8*i +: 8];
                wr_ptr[int'(wr_addr[w] % NB)] = (w + 1) % NW;
            end
        end
    endtask

    // Entered just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        logic [NR-1:0] exp_v;
        #1;
        model_eval();
        check("rd_ready", 64'(rd_req_ready), 64'(exp_rd_rdy));
        check("wr_ready", 64'(wr_req_ready), 64'(exp_wr_rdy));
        model_commit();
        exp_v = exp_rd_rdy;
        @(posedge clk);
        #1;
        check("resp_valid", 64'(rd_resp_valid), 64'(exp_v));
        for (int p = 0; p < NR; p++) check("resp_data", 64'(rd_resp_data[p]), 64'(last_data[p]));
        @(negedge clk);
    endtask

    task automatic idle();
        rd_req_valid = '0;
        wr_req_valid = '0;
        wr_strb = '0;
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        logic [AW-1:0] ra0, ra1;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [3:0]    ws;
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] exp_d0, exp_d1;
    } vec_t;

    vec_t vecs [12];
    logic [NR-1:0] alt_exp [4];
    logic [DW-1:0] fwd_exp;
    logic [NR-1:0] granted_last;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom % 10 == 0) return AW'(MS + ($urandom % MS));
        return AW'($urandom % 16);
    endfunction

    initial begin
`ifdef BANKED_MEM_FWD_EN
        fwd_exp = 32'h1234_5678;
`else
        fwd_exp = 32'h0000_0000;
`endif
        //          rv     ra0    ra1   wv  wa     wd             ws     rdy    d0            d1
        vecs[0]  = '{2'b00, 0,     0,    1, 5,     32'hDEADBEEF,  4'hF,  2'b00, 0,            0};
        vecs[1]  = '{2'b00, 0,     0,    1, 5,     32'h000000AA,  4'h1,  2'b00, 0,            0};
        vecs[2]  = '{2'b01, 5,     0,    0, 0,     0,             4'h0,  2'b01, 32'hDEADBEAA, 0};
        vecs[3]  = '{2'b11, 1,     2,    0, 0,     0,             4'h0,  2'b11, fill(1),      fill(2)};
        vecs[4]  = '{2'b00, 0,     0,    1, 8,     0,             4'hF,  2'b00, 0,            0};
        vecs[5]  = '{2'b01, 8,     0,    1, 8,     32'h12345678,  4'hF,  2'b01, fwd_exp,      0};
        vecs[6]  = '{2'b10, 0,     8,    0, 0,     0,             4'h0,  2'b10, 0,            32'h12345678};
        vecs[7]  = '{2'b00, 0,     0,    1, 976,   32'hCAFEF00D,  4'hF,  2'b00, 0,            0};
        vecs[8]  = '{2'b01, 2000,  0,    1, 2000,  32'hFFFFFFFF,  4'hF,  2'b01, 0,            0};
        vecs[9]  = '{2'b11, 976,   1,    0, 0,     0,             4'h0,  2'b11, 32'hCAFEF00D, fill(1)};
        vecs[10] = '{2'b00, 0,     0,    1, 5,     32'h0,         4'h0,  2'b00, 0,            0};
        vecs[11] = '{2'b11, 5,     2000, 0, 0,     0,             4'h0,  2'b11, 32'hDEADBEAA, 0};
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;

        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Known contents everywhere so later reads are deterministic.
        for (int a = 0; a < MS; a++) begin
            wr_req_valid = 1'b1; wr_addr[0] = AW'(a); wr_data[0] = fill(AW'(a)); wr_strb[0] = 4'hF;
            step();
        end
        idle();

        // Reset arriving with a response in flight and requests held through reset.
        rd_req_valid = 2'b01; rd_addr[0] = 3;
        @(posedge clk); #1;
        check("pre_rst_valid", 64'(rd_resp_valid), 64'(2'b01));
        check("pre_rst_data", 64'(rd_resp_data[0]), 64'(fill(3)));
        reset_n = 1'b0;
        rd_req_valid = 2'b11; rd_addr[0] = 0; rd_addr[1] = 4;
        #1;
        check("rst_valid", 64'(rd_resp_valid), 64'(0));
        check("rst_data0", 64'(rd_resp_data[0]), 64'(0));
        check("rst_data1", 64'(rd_resp_data[1]), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", 64'(rd_resp_valid), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check("post_rst_valid", 64'(rd_resp_valid), 64'(0));

        // Same-bank contention: grants alternate starting at port 0.
        for (int i = 0; i < 4; i++) begin
            check("alt_grant", 64'(rd_req_ready), 64'(alt_exp[i]));
            step();
            if (i % 2 == 0) check("alt_data0", 64'(rd_resp_data[0]), 64'(fill(0)));
            else            check("alt_data1", 64'(rd_resp_data[1]), 64'(fill(4)));
        end
        idle();
        step();

        foreach (vecs[i]) begin
            rd_req_valid = vecs[i].rv; rd_addr[0] = vecs[i].ra0; rd_addr[1] = vecs[i].ra1;
            wr_req_valid = vecs[i].wv; wr_addr[0] = vecs[i].wa; wr_data[0] = vecs[i].wd; wr_strb[0] = vecs[i].ws;
            #1;
            check("vec_rd_ready", 64'(rd_req_ready), 64'(vecs[i].exp_rdy));
            check("vec_wr_ready", 64'(wr_req_ready), 64'(vecs[i].wv));
            step();
            check("vec_resp_valid", 64'(rd_resp_valid), 64'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy[0]) check("vec_data0", 64'(rd_resp_data[0]), 64'(vecs[i].exp_d0));
            if (vecs[i].exp_rdy[1]) check("vec_data1", 64'(rd_resp_data[1]), 64'(vecs[i].exp_d1));
        end
        idle();
        step();
        rd_req_valid = 2'b01; rd_addr[0] = 8;
        step();
        check("after_fwd_read", 64'(rd_resp_data[0]), 64'(32'h12345678));
        idle();
        step();

        // Random traffic; denied requests are held as the protocol requires.
        granted_last = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NR; p++) begin
                if (!(rd_req_valid[p] && !granted_last[p])) begin
                    rd_req_valid[p] = ($urandom % 4) != 0;
                    rd_addr[p] = rand_addr();
                end
            end
            if (!(wr_req_valid[0] && !exp_wr_rdy[0])) begin
                wr_req_valid[0] = ($urandom % 3) == 0;
                wr_addr[0] = rand_addr();
                wr_data[0] = $urandom;
                wr_strb[0] = 4'($urandom % 16);
            end
            step();
            granted_last = exp_rd_rdy;
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
